// File: rtl/lock_pkg.sv
// Shared definitions for the front-panel lock supervisor.
//   state_t           : FSM states; the encoding is the StateCode shown on the panel
//   PKG_DEFAULT_CODE  : factory code, first-entered bit is the MSB of the low CODE_LEN bits
//   timer_width()     : counter width able to hold max(LOCKOUT_CYCLES, OPEN_CYCLES) - 1
package lock_pkg;

    localparam int unsigned STATE_W    = 3;
    localparam int unsigned BIT_CNT_W  = 4;
    localparam int unsigned FAIL_CNT_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'b000,
        ST_ENTRY   = 3'b001,
        ST_CHECK   = 3'b010,
        ST_OPEN    = 3'b011,
        ST_PROGRAM = 3'b100,
        ST_LOCKOUT = 3'b101
    } state_t;

    localparam logic [7:0] PKG_DEFAULT_CODE = 8'b0011_0010;

    // Timers are loaded with (cycles - 1) and count down to zero.
    function automatic int unsigned timer_width(input int unsigned lockout_cycles,
                                                input int unsigned open_cycles);
        int unsigned longest;
        longest = (lockout_cycles > open_cycles) ? lockout_cycles : open_cycles;
        return (longest < 2) ? 1 : $clog2(longest);
    endfunction

endpackage

// File: rtl/lock_access_supervisor_if.sv
// Panel-side signal bundle of the lock supervisor.
//   x, Enter, Relock, ProgMode : switch / pushbutton inputs (Enter, Relock active-low)
//   Open, Alarm                : lock and lockout indicators
//   StateCode, BitCount        : 3-bit status for the seven-segment decoder
//   FailCount                  : consecutive failed attempts
interface lock_access_supervisor_if;
    import lock_pkg::*;

    logic                  x;
    logic                  Enter;
    logic                  Relock;
    logic                  ProgMode;
    logic                  Open;
    logic                  Alarm;
    logic [STATE_W-1:0]    StateCode;
    logic [2:0]            BitCount;
    logic [FAIL_CNT_W-1:0] FailCount;

    modport master (
        output x, Enter, Relock, ProgMode,
        input  Open, Alarm, StateCode, BitCount, FailCount
    );

    modport slave (
        input  x, Enter, Relock, ProgMode,
        output Open, Alarm, StateCode, BitCount, FailCount
    );

endinterface

// File: rtl/button_conditioner.sv
// Active-low pushbutton conditioner: 2-flop sync, debounce, one-cycle press pulse.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_btn_n      : raw button level (0 = pressed)
//   o_pulse      : one-cycle pulse when the debounced level falls 1->0
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn_n,
    output logic o_pulse
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_meta;
    logic             r_sync;
    logic             r_level;
    logic             r_level_d;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pulse;

    // Released (1) is the idle level so reset never produces a press pulse.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta    <= 1'b1;
            r_sync    <= 1'b1;
            r_level   <= 1'b1;
            r_level_d <= 1'b1;
            r_cnt     <= '0;
            r_pulse   <= 1'b0;
        end else begin
            r_meta    <= i_btn_n;
            r_sync    <= r_meta;
            r_level_d <= r_level;
            r_pulse   <= r_level_d & ~r_level;
            // Any bounce back to the accepted level restarts the stability count.
            if (r_sync == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_level <= r_sync;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/lock_access_supervisor.sv
// Combination-lock supervisor: serial code entry, compare, fail counting with
// timed lockout, auto-relock after the open window, and reprogramming while open.
//   Clock, Reset : system clock, asynchronous active-high reset
//   bus (slave)  : x / Enter / Relock / ProgMode in; Open / Alarm / StateCode /
//                  BitCount / FailCount out (all outputs registered)
module lock_access_supervisor
    import lock_pkg::*;
#(
    parameter int unsigned         CODE_LEN        = 6,
    parameter logic [CODE_LEN-1:0] DEFAULT_CODE    = CODE_LEN'(PKG_DEFAULT_CODE),
    parameter int unsigned         MAX_FAIL        = 3,
    parameter int unsigned         LOCKOUT_CYCLES  = 50_000_000,
    parameter int unsigned         OPEN_CYCLES     = 250_000_000,
    parameter int unsigned         DEBOUNCE_CYCLES = 500_000
) (
    input logic                     Clock,
    input logic                     Reset,
    lock_access_supervisor_if.slave bus
);

    localparam int unsigned TIMER_W = timer_width(LOCKOUT_CYCLES, OPEN_CYCLES);
    localparam logic [TIMER_W-1:0]    OPEN_LOAD  = TIMER_W'(OPEN_CYCLES - 1);
    localparam logic [TIMER_W-1:0]    LOCK_LOAD  = TIMER_W'(LOCKOUT_CYCLES - 1);
    localparam logic [BIT_CNT_W-1:0]  BITS_FULL  = BIT_CNT_W'(CODE_LEN);
    localparam logic [FAIL_CNT_W-1:0] FAIL_LIMIT = FAIL_CNT_W'(MAX_FAIL);

    logic                  w_enter_p;
    logic                  w_relock_p;
    logic                  r_x_meta;
    logic                  r_x_sync;
    logic                  r_prog_meta;
    logic                  r_prog_sync;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CODE_LEN-1:0]   r_entry;
    logic [CODE_LEN-1:0]   w_entry_nxt;
    logic [CODE_LEN-1:0]   w_entry_shift;
    logic [CODE_LEN-1:0]   r_code;
    logic [CODE_LEN-1:0]   w_code_nxt;
    logic [BIT_CNT_W-1:0]  r_bit_count;
    logic [BIT_CNT_W-1:0]  w_bit_nxt;
    logic [BIT_CNT_W-1:0]  w_bit_inc;
    logic [FAIL_CNT_W-1:0] r_fail_count;
    logic [FAIL_CNT_W-1:0] w_fail_nxt;
    logic [FAIL_CNT_W-1:0] w_fail_inc;
    logic [TIMER_W-1:0]    r_timer;
    logic [TIMER_W-1:0]    w_timer_nxt;
    logic                  r_open;
    logic                  w_open_nxt;
    logic                  r_alarm;
    logic                  w_alarm_nxt;

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter_btn (
        .i_clk   (Clock),
        .i_rst   (Reset),
        .i_btn_n (bus.Enter),
        .o_pulse (w_enter_p)
    );

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_relock_btn (
        .i_clk   (Clock),
        .i_rst   (Reset),
        .i_btn_n (bus.Relock),
        .o_pulse (w_relock_p)
    );

    // Switch synchronizers.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_x_meta    <= 1'b0;
            r_x_sync    <= 1'b0;
            r_prog_meta <= 1'b0;
            r_prog_sync <= 1'b0;
        end else begin
            r_x_meta    <= bus.x;
            r_x_sync    <= r_x_meta;
            r_prog_meta <= bus.ProgMode;
            r_prog_sync <= r_prog_meta;
        end
    end

    assign w_entry_shift = {r_entry[CODE_LEN-2:0], r_x_sync};
    assign w_bit_inc     = r_bit_count + BIT_CNT_W'(1);
    assign w_fail_inc    = r_fail_count + FAIL_CNT_W'(1);

    // FSM and datapath registers.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state      <= ST_IDLE;
            r_entry      <= '0;
            r_code       <= DEFAULT_CODE;
            r_bit_count  <= '0;
            r_fail_count <= '0;
            r_timer      <= '0;
            r_open       <= 1'b0;
            r_alarm      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_entry      <= w_entry_nxt;
            r_code       <= w_code_nxt;
            r_bit_count  <= w_bit_nxt;
            r_fail_count <= w_fail_nxt;
            r_timer      <= w_timer_nxt;
            r_open       <= w_open_nxt;
            r_alarm      <= w_alarm_nxt;
        end
    end

    // Next-state logic; priority is timer expiry, then relock, then enter.
    always_comb begin
        w_state_nxt = r_state;
        w_entry_nxt = r_entry;
        w_code_nxt  = r_code;
        w_bit_nxt   = r_bit_count;
        w_fail_nxt  = r_fail_count;
        w_timer_nxt = r_timer;

        case (r_state)
            ST_IDLE: begin
                if (!w_relock_p && w_enter_p) begin
                    w_entry_nxt = w_entry_shift;
                    w_bit_nxt   = BIT_CNT_W'(1);
                    w_state_nxt = ST_ENTRY;
                end
            end

            ST_ENTRY: begin
                if (w_relock_p) begin
                    w_entry_nxt = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else if (r_bit_count == BITS_FULL) begin
                    w_state_nxt = ST_CHECK;
                end else if (w_enter_p) begin
                    w_entry_nxt = w_entry_shift;
                    w_bit_nxt   = w_bit_inc;
                end
            end

            ST_CHECK: begin
                w_bit_nxt = '0;
                if (r_entry == r_code) begin
                    w_fail_nxt  = '0;
                    w_timer_nxt = OPEN_LOAD;
                    w_state_nxt = ST_OPEN;
                end else if (w_fail_inc == FAIL_LIMIT) begin
                    w_fail_nxt  = FAIL_LIMIT;
                    w_timer_nxt = LOCK_LOAD;
                    w_state_nxt = ST_LOCKOUT;
                end else begin
                    w_fail_nxt  = w_fail_inc;
                    w_state_nxt = ST_IDLE;
                end
            end

            ST_OPEN: begin
                if (r_timer == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_timer_nxt = r_timer - TIMER_W'(1);
                    if (w_relock_p) begin
                        w_state_nxt = ST_IDLE;
                    end else if (w_enter_p && r_prog_sync) begin
                        // The press that enters PROGRAM carries no code bit.
                        w_bit_nxt   = '0;
                        w_state_nxt = ST_PROGRAM;
                    end
                end
            end

            ST_PROGRAM: begin
                if (w_relock_p) begin
                    w_bit_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else if (w_enter_p) begin
                    w_entry_nxt = w_entry_shift;
                    if (w_bit_inc == BITS_FULL) begin
                        w_code_nxt  = w_entry_shift;
                        w_bit_nxt   = '0;
                        w_timer_nxt = OPEN_LOAD;
                        w_state_nxt = ST_OPEN;
                    end else begin
                        w_bit_nxt = w_bit_inc;
                    end
                end
            end

            ST_LOCKOUT: begin
                if (r_timer == '0) begin
                    w_fail_nxt  = '0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_timer_nxt = r_timer - TIMER_W'(1);
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_open_nxt  = (w_state_nxt == ST_OPEN) || (w_state_nxt == ST_PROGRAM);
        w_alarm_nxt = (w_state_nxt == ST_LOCKOUT);
    end

    assign bus.Open      = r_open;
    assign bus.Alarm     = r_alarm;
    assign bus.StateCode = r_state;
    assign bus.BitCount  = 3'(r_bit_count);
    assign bus.FailCount = r_fail_count;

endmodule

// File: tb/tb_lock_access_supervisor.sv
// Directed plus randomized bench for lock_access_supervisor with short timers.
module tb_lock_access_supervisor;

    localparam int unsigned DEB = 2;
    localparam int unsigned OPN = 30;
    localparam int unsigned LCK = 20;

    localparam logic [2:0] S_IDLE    = 3'b000;
    localparam logic [2:0] S_ENTRY   = 3'b001;
    localparam logic [2:0] S_CHECK   = 3'b010;
    localparam logic [2:0] S_OPEN    = 3'b011;
    localparam logic [2:0] S_PROGRAM = 3'b100;
    localparam logic [2:0] S_LOCKOUT = 3'b101;

    logic Clock = 1'b0;
    logic Reset = 1'b1;

    lock_access_supervisor_if bus();

    lock_access_supervisor #(
        .DEBOUNCE_CYCLES (DEB),
        .OPEN_CYCLES     (OPN),
        .LOCKOUT_CYCLES  (LCK)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    int n_vec = 0;
    int n_err = 0;

    // Run-length monitors for Open, Alarm and the CHECK state.
    int open_run = 0, last_open_run = 0;
    int alarm_run = 0, last_alarm_run = 0;
    int check_run = 0, last_check_run = 0, n_check = 0;

    always @(negedge Clock) begin
        if (bus.Open === 1'b1) open_run++;
        else if (open_run != 0) begin last_open_run = open_run; open_run = 0; end
        if (bus.Alarm === 1'b1) alarm_run++;
        else if (alarm_run != 0) begin last_alarm_run = alarm_run; alarm_run = 0; end
        if (bus.StateCode === S_CHECK) check_run++;
        else if (check_run != 0) begin last_check_run = check_run; check_run = 0; n_check++; end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [2:0] exp);
        check(tag, 32'(bus.StateCode), 32'(exp));
    endtask
    task automatic chk_bits(input string tag, input logic [2:0] exp);
        check(tag, 32'(bus.BitCount), 32'(exp));
    endtask
    task automatic chk_fail(input string tag, input logic [1:0] exp);
        check(tag, 32'(bus.FailCount), 32'(exp));
    endtask
    task automatic chk_open(input string tag, input logic exp);
        check(tag, 32'(bus.Open), 32'(exp));
    endtask
    task automatic chk_alarm(input string tag, input logic exp);
        check(tag, 32'(bus.Alarm), 32'(exp));
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge Clock);
    endtask

    task automatic wait_state(input logic [2:0] exp, input int bound, input string tag);
        int k = 0;
        while (bus.StateCode !== exp && k < bound) begin
            cyc(1);
            k++;
        end
        chk_state(tag, exp);
    endtask

    task automatic press_enter(input logic b, input int hold);
        bus.x     = b;
        bus.Enter = 1'b0;
        cyc(hold);
        bus.Enter = 1'b1;
        cyc(6);
    endtask

    task automatic press_relock();
        bus.Relock = 1'b0;
        cyc(8);
        bus.Relock = 1'b1;
        cyc(6);
    endtask

    task automatic enter_code(input logic [5:0] c, input bit rnd);
        int hold;
        for (int i = 5; i >= 0; i--) begin
            hold = rnd ? 7 + int'($urandom_range(0, 4)) : 8;
            press_enter(c[i], hold);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no completion expected finish");
        $fatal(1, "timeout");
    end

    logic [5:0] m_code;
    int         m_fail;
    logic [5:0] guess;
    logic [5:0] newc;
    logic [2:0] exp_state;
    int         snap;

    initial begin
        bus.x = 1'b0; bus.Enter = 1'b1; bus.Relock = 1'b1; bus.ProgMode = 1'b0;
        cyc(3);
        chk_state("rst_state", S_IDLE);
        chk_open("rst_open", 1'b0);
        chk_alarm("rst_alarm", 1'b0);
        Reset = 1'b0;
        cyc(2);
        chk_bits("rst_bits", 3'd0);
        chk_fail("rst_fail", 2'd0);

        // Correct default code
        snap = n_check;
        press_enter(1'b1, 8);
        chk_state("entry_state", S_ENTRY);
        chk_bits("entry_bits1", 3'd1);
        press_enter(1'b1, 8); press_enter(1'b0, 8); press_enter(1'b0, 8); press_enter(1'b1, 8);
        chk_bits("entry_bits5", 3'd5);
        chk_state("entry_state5", S_ENTRY);
        press_enter(1'b0, 8);
        chk_state("open_state", S_OPEN);
        chk_open("open_flag", 1'b1);
        chk_bits("open_bits", 3'd0);
        check("check_visits", 32'(n_check - snap), 32'd1);
        check("check_len", 32'(last_check_run), 32'd1);
        wait_state(S_IDLE, 60, "open_expire");
        cyc(2);
        check("open_len", 32'(last_open_run), 32'(OPN));
        chk_open("open_after", 1'b0);

        // Three wrong codes -> lockout
        enter_code(6'b000000, 1'b0);
        chk_state("wrong1_state", S_IDLE);
        chk_fail("wrong1_fail", 2'd1);
        enter_code(6'b000000, 1'b0);
        chk_fail("wrong2_fail", 2'd2);
        enter_code(6'b000000, 1'b0);
        chk_state("lock_state", S_LOCKOUT);
        chk_alarm("lock_alarm", 1'b1);
        chk_fail("lock_fail", 2'd3);
        bus.x = 1'b1; bus.Enter = 1'b0; bus.Relock = 1'b0;
        cyc(7);
        chk_state("lock_ignore", S_LOCKOUT);
        chk_bits("lock_ignore_bits", 3'd0);
        bus.Enter = 1'b1; bus.Relock = 1'b1;
        wait_state(S_IDLE, 40, "lock_exit");
        cyc(2);
        check("lock_len", 32'(last_alarm_run), 32'(LCK));
        chk_fail("lock_fail_clr", 2'd0);
        chk_alarm("lock_alarm_clr", 1'b0);

        // Abort in ENTRY keeps FailCount
        enter_code(6'b000000, 1'b0);
        press_enter(1'b1, 8); press_enter(1'b0, 8); press_enter(1'b1, 8);
        chk_bits("abort_pre_bits", 3'd3);
        press_relock();
        chk_state("abort_state", S_IDLE);
        chk_bits("abort_bits", 3'd0);
        chk_fail("abort_fail", 2'd1);

        // Abort in PROGRAM keeps the code
        enter_code(6'b110010, 1'b0);
        chk_state("open2_state", S_OPEN);
        chk_fail("open2_fail", 2'd0);
        bus.ProgMode = 1'b1;
        press_enter(1'b0, 8);
        chk_state("prog_state", S_PROGRAM);
        chk_open("prog_open", 1'b1);
        chk_bits("prog_bits0", 3'd0);
        press_enter(1'b1, 8); press_enter(1'b0, 8);
        chk_bits("prog_bits2", 3'd2);
        press_relock();
        chk_state("prog_abort", S_IDLE);
        chk_open("prog_abort_open", 1'b0);
        bus.ProgMode = 1'b0;
        enter_code(6'b110010, 1'b0);
        chk_state("code_kept", S_OPEN);

        // Reprogram to 101011
        bus.ProgMode = 1'b1;
        press_enter(1'b0, 8);
        chk_state("prog2_state", S_PROGRAM);
        enter_code(6'b101011, 1'b0);
        chk_state("prog_done", S_OPEN);
        chk_bits("prog_done_bits", 3'd0);
        bus.ProgMode = 1'b0;
        press_relock();
        chk_state("relock_state", S_IDLE);
        enter_code(6'b110010, 1'b0);
        chk_state("old_code_state", S_IDLE);
        chk_fail("old_code_fail", 2'd1);
        enter_code(6'b101011, 1'b0);
        chk_state("new_code_state", S_OPEN);
        chk_fail("new_code_fail", 2'd0);

        // Asynchronous reset while open
        Reset = 1'b1;
        #1;
        chk_open("async_open", 1'b0);
        chk_state("async_state", S_IDLE);
        cyc(2);
        Reset = 1'b0;
        cyc(2);
        enter_code(6'b110010, 1'b0);
        chk_state("code_reverted", S_OPEN);
        press_relock();
        chk_state("relock2_state", S_IDLE);

        // Simultaneous Enter and Relock in ENTRY
        press_enter(1'b1, 8); press_enter(1'b1, 8);
        chk_bits("simul_pre_bits", 3'd2);
        bus.x = 1'b1; bus.Enter = 1'b0; bus.Relock = 1'b0;
        cyc(8);
        bus.Enter = 1'b1; bus.Relock = 1'b1;
        cyc(6);
        chk_state("simul_state", S_IDLE);
        chk_bits("simul_bits", 3'd0);

        // Long hold gives a single press
        bus.x = 1'b1; bus.Enter = 1'b0;
        cyc(100);
        chk_state("hold_state", S_ENTRY);
        chk_bits("hold_bits", 3'd1);
        bus.Enter = 1'b1;
        cyc(6);
        chk_bits("hold_bits_rel", 3'd1);
        press_relock();
        chk_state("hold_clear", S_IDLE);

        // Randomized attempts against the reference model
        m_code = 6'b110010;
        m_fail = 0;
        for (int t = 0; t < 12; t++) begin
            if ($urandom_range(0, 1) == 1) guess = m_code;
            else guess = 6'($urandom);
            enter_code(guess, 1'b1);
            if (guess == m_code) begin
                exp_state = S_OPEN; m_fail = 0;
            end else if (m_fail + 1 == 3) begin
                exp_state = S_LOCKOUT; m_fail = 3;
            end else begin
                exp_state = S_IDLE; m_fail++;
            end
            chk_state("rnd_state", exp_state);
            chk_fail("rnd_fail", 2'(m_fail));
            chk_open("rnd_open", exp_state == S_OPEN);
            chk_alarm("rnd_alarm", exp_state == S_LOCKOUT);
            if (exp_state == S_LOCKOUT) begin
                wait_state(S_IDLE, 40, "rnd_lock_exit");
                m_fail = 0;
                chk_fail("rnd_lock_fail", 2'd0);
            end else if (exp_state == S_OPEN) begin
                case ($urandom_range(0, 2))
                    0: begin
                        press_relock();
                        chk_state("rnd_relock", S_IDLE);
                    end
                    1: wait_state(S_IDLE, 60, "rnd_expire");
                    default: begin
                        newc = 6'($urandom);
                        bus.ProgMode = 1'b1;
                        press_enter(1'($urandom), 8);
                        chk_state("rnd_prog", S_PROGRAM);
                        enter_code(newc, 1'b1);
                        chk_state("rnd_prog_done", S_OPEN);
                        m_code = newc;
                        bus.ProgMode = 1'b0;
                        press_relock();
                        chk_state("rnd_prog_relock", S_IDLE);
                    end
                endcase
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
